// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared state encoding and sizing helper for the shift-add multiplier sequencer
package mult_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, EVAL, SHIFT, DONE} mult_state_t;

    // Iteration counter needs at least one bit even for N=1 or N=2.
    function automatic int cnt_width(input int n);
        return ($clog2(n) > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mult_iter_counter.sv
// rtl/mult_iter_counter.sv - per-bit iteration counter with terminal flag at N-1
module mult_iter_counter #(
    parameter int N     = 4,
    parameter int CNT_W = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic terminal
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CNT_W'(1);
        end
    end

    assign terminal = (count == CNT_W'(N - 1));

endmodule

// File: rtl/shift_mult_control.sv
// rtl/shift_mult_control.sv - operand capture and load/add/shift sequencing for the AQ multiplier datapath
module shift_mult_control
    import mult_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] m_in,
    input  logic [N-1:0] q_in,
    output logic [N-1:0] m_out,
    output logic [N-1:0] q_out,
    input  logic         q0,
    output logic         load,
    output logic         add,
    output logic         shift,
    output logic         busy,
    output logic         done,
    input  logic         out_ready
);

    localparam int CNT_W = cnt_width(N);

    mult_state_t state, state_nx;
    logic        accept;
    logic        cnt_clear, cnt_inc, cnt_term;
    logic        load_c, add_c, shift_c;

    assign in_ready = (state == IDLE) & ~reset;
    assign accept   = in_valid & in_ready;

    mult_iter_counter #(
        .N     (N),
        .CNT_W (CNT_W)
    ) u_iter_counter (
        .clock    (clock),
        .reset    (reset),
        .clear    (cnt_clear),
        .inc      (cnt_inc),
        .terminal (cnt_term)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Operands are held from accept through DONE so the adder sees a stable multiplicand.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            m_out <= '0;
            q_out <= '0;
        end else if (accept) begin
            m_out <= m_in;
            q_out <= q_in;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_clear = 1'b0;
        cnt_inc   = 1'b0;
        load_c    = 1'b0;
        add_c     = 1'b0;
        shift_c   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_nx = LOAD;
            end
            LOAD: begin
                load_c    = 1'b1;
                cnt_clear = 1'b1;
                state_nx  = EVAL;
            end
            EVAL: begin
                add_c    = q0;
                state_nx = SHIFT;
            end
            SHIFT: begin
                shift_c = 1'b1;
                if (cnt_term) begin
                    state_nx = DONE;
                end else begin
                    cnt_inc  = 1'b1;
                    state_nx = EVAL;
                end
            end
            DONE: begin
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Masking with reset keeps strobes quiet for the whole reset pulse, not just after the flop clears.
    assign load  = load_c  & ~reset;
    assign add   = add_c   & ~reset;
    assign shift = shift_c & ~reset;
    assign busy  = ((state == LOAD) | (state == EVAL) | (state == SHIFT)) & ~reset;
    assign done  = (state == DONE) & ~reset;

endmodule

// File: tb/tb_shift_mult_control.sv
// tb/tb_shift_mult_control.sv - self-checking bench with AQ datapath model and product scoreboard
module tb_shift_mult_control;

    localparam int N = 4;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [N-1:0] m_in = '0;
    logic [N-1:0] q_in = '0;
    logic         in_ready, load, add, shift, busy, done, q0;
    logic [N-1:0] m_out, q_out;

    logic         dp_c = 1'b0;
    logic [N-1:0] dp_a = '0;
    logic [N-1:0] dp_q = '0;
    logic [4:0]   obs;

    int n_cmp = 0;
    int n_bad = 0;
    logic [2*N-1:0] sb[$];

    assign q0 = dp_q[0];

    shift_mult_control #(.N(N)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .m_in      (m_in),
        .q_in      (q_in),
        .m_out     (m_out),
        .q_out     (q_out),
        .q0        (q0),
        .load      (load),
        .add       (add),
        .shift     (shift),
        .busy      (busy),
        .done      (done),
        .out_ready (out_ready)
    );

    always #5 clock = ~clock;

    // Advance to the next falling edge, sample {load,add,shift,busy,done}, then clock the AQ model.
    task automatic cyc();
        @(negedge clock);
        obs = {load, add, shift, busy, done};
        if (load) begin
            {dp_c, dp_a, dp_q} = {1'b0, {N{1'b0}}, q_out};
        end else if (add) begin
            {dp_c, dp_a} = {1'b0, dp_a} + {1'b0, m_out};
        end else if (shift) begin
            {dp_c, dp_a, dp_q} = {1'b0, dp_c, dp_a, dp_q[N-1:1]};
        end
    endtask

    // Strobe pattern for cycle c after accept (cycle 0), assuming out_ready already high at DONE.
    function automatic logic [4:0] exp_sig(input int c, input logic [N-1:0] q);
        logic [4:0] e;
        e = 5'b00000;
        if (c == 1) e = 5'b10010;
        else if (c >= 2 && c <= 2*N && (c % 2) == 0) e = {1'b0, q[(c-2)/2], 1'b0, 1'b1, 1'b0};
        else if (c >= 3 && c <= 2*N+1) e = 5'b00110;
        else if (c == 2*N+2) e = 5'b00001;
        return e;
    endfunction

    function automatic logic [2*N-1:0] prod(input logic [N-1:0] m, input logic [N-1:0] q);
        logic [2*N-1:0] mw, qw;
        mw = {{N{1'b0}}, m};
        qw = {{N{1'b0}}, q};
        return mw * qw;
    endfunction

    task automatic test_reset();
        logic [2*N-1:0] zq;
        #2;
        n_cmp++;
        if ({in_ready, load, add, shift, busy, done} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b expected 000000", {in_ready, load, add, shift, busy, done});
        end
        zq = {m_out, q_out};
        n_cmp++;
        if (zq !== '0) begin
            n_bad++;
            $display("FAIL reset_operands: got %h expected 0", zq);
        end
        cyc();
        cyc();
        reset = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_release_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_multiply(input logic [N-1:0] m, input logic [N-1:0] q, input string name);
        logic [2*N-1:0] e;
        cyc();
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_ready: got %b expected 1", name, in_ready);
        end
        in_valid = 1'b1;
        m_in = m;
        q_in = q;
        sb.push_back(prod(m, q));
        for (int c = 1; c <= 2*N+2; c++) begin
            cyc();
            if (c == 1) in_valid = 1'b0;
            n_cmp++;
            if (obs !== exp_sig(c, q)) begin
                n_bad++;
                $display("FAIL %s_strobes_c%0d: got %b expected %b", name, c, obs, exp_sig(c, q));
            end
            if (c == 2*N+2) begin
                e = (sb.size() > 0) ? sb.pop_front() : 'x;
                n_cmp++;
                if ({dp_a, dp_q} !== e) begin
                    n_bad++;
                    $display("FAIL %s_product: got %h expected %h", name, {dp_a, dp_q}, e);
                end
                n_cmp++;
                if ({m_out, q_out} !== {m, q}) begin
                    n_bad++;
                    $display("FAIL %s_operands: got %h expected %h", name, {m_out, q_out}, {m, q});
                end
                out_ready = 1'b1;
            end
        end
        cyc();
        out_ready = 1'b0;
        n_cmp++;
        if ({in_ready, obs} !== 6'b100000) begin
            n_bad++;
            $display("FAIL %s_idle_after: got %b expected 100000", name, {in_ready, obs});
        end
    endtask

    task automatic test_done_hold();
        logic [2*N-1:0] e;
        cyc();
        in_valid = 1'b1;
        m_in = 4'd11;
        q_in = 4'd13;
        sb.push_back(prod(4'd11, 4'd13));
        for (int c = 1; c <= 14; c++) begin
            cyc();
            if (c == 1) in_valid = 1'b0;
            if (c <= 9) begin
                n_cmp++;
                if (obs !== exp_sig(c, 4'd13)) begin
                    n_bad++;
                    $display("FAIL hold_strobes_c%0d: got %b expected %b", c, obs, exp_sig(c, 4'd13));
                end
            end else if (c <= 13) begin
                n_cmp++;
                if ({in_ready, obs} !== 6'b000001) begin
                    n_bad++;
                    $display("FAIL hold_done_c%0d: got %b expected 000001", c, {in_ready, obs});
                end
                if (c == 10) begin
                    e = (sb.size() > 0) ? sb.pop_front() : 'x;
                    n_cmp++;
                    if ({dp_a, dp_q} !== e) begin
                        n_bad++;
                        $display("FAIL hold_product: got %h expected %h", {dp_a, dp_q}, e);
                    end
                end
                if (c == 13) out_ready = 1'b1;
            end else begin
                out_ready = 1'b0;
                n_cmp++;
                if ({in_ready, obs} !== 6'b100000) begin
                    n_bad++;
                    $display("FAIL hold_release: got %b expected 100000", {in_ready, obs});
                end
            end
        end
    endtask

    task automatic test_ignore_inputs();
        logic [2*N-1:0] e;
        cyc();
        in_valid = 1'b1;
        m_in = 4'd11;
        q_in = 4'd13;
        out_ready = 1'b1;
        sb.push_back(prod(4'd11, 4'd13));
        for (int c = 1; c <= 11; c++) begin
            cyc();
            if (c == 1) in_valid = 1'b0;
            if (c == 5) begin
                in_valid = 1'b1;
                m_in = 4'd3;
                q_in = 4'd3;
            end
            if (c == 6) begin
                in_valid = 1'b0;
                n_cmp++;
                if ({m_out, q_out} !== {4'd11, 4'd13}) begin
                    n_bad++;
                    $display("FAIL ignore_operands: got %h expected %h", {m_out, q_out}, {4'd11, 4'd13});
                end
            end
            n_cmp++;
            if (obs !== exp_sig(c, 4'd13)) begin
                n_bad++;
                $display("FAIL ignore_strobes_c%0d: got %b expected %b", c, obs, exp_sig(c, 4'd13));
            end
            if (c == 10) begin
                e = (sb.size() > 0) ? sb.pop_front() : 'x;
                n_cmp++;
                if ({dp_a, dp_q} !== e) begin
                    n_bad++;
                    $display("FAIL ignore_product: got %h expected %h", {dp_a, dp_q}, e);
                end
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [2*N-1:0] e;
        cyc();
        in_valid = 1'b1;
        m_in = 4'd11;
        q_in = 4'd13;
        out_ready = 1'b1;
        sb.push_back(prod(4'd11, 4'd13));
        for (int c = 1; c <= 21; c++) begin
            cyc();
            if (c == 2) begin
                m_in = 4'd15;
                q_in = 4'd15;
            end
            if (c == 12) in_valid = 1'b0;
            if (c == 11) begin
                n_cmp++;
                if ({in_ready, obs} !== 6'b100000) begin
                    n_bad++;
                    $display("FAIL b2b_gap: got %b expected 100000", {in_ready, obs});
                end
                sb.push_back(prod(4'd15, 4'd15));
            end else begin
                n_cmp++;
                if (obs !== ((c < 11) ? exp_sig(c, 4'd13) : exp_sig(c - 11, 4'd15))) begin
                    n_bad++;
                    $display("FAIL b2b_strobes_c%0d: got %b", c, obs);
                end
            end
            if (c == 10 || c == 21) begin
                e = (sb.size() > 0) ? sb.pop_front() : 'x;
                n_cmp++;
                if ({dp_a, dp_q} !== e) begin
                    n_bad++;
                    $display("FAIL b2b_product_c%0d: got %h expected %h", c, {dp_a, dp_q}, e);
                end
            end
        end
        cyc();
        out_ready = 1'b0;
        n_cmp++;
        if ({in_ready, obs} !== 6'b100000) begin
            n_bad++;
            $display("FAIL b2b_idle_after: got %b expected 100000", {in_ready, obs});
        end
    endtask

    task automatic test_abort();
        cyc();
        in_valid = 1'b1;
        m_in = 4'd11;
        q_in = 4'd13;
        sb.push_back(prod(4'd11, 4'd13));
        for (int c = 1; c <= 5; c++) begin
            cyc();
            if (c == 1) in_valid = 1'b0;
            n_cmp++;
            if (obs !== exp_sig(c, 4'd13)) begin
                n_bad++;
                $display("FAIL abort_strobes_c%0d: got %b expected %b", c, obs, exp_sig(c, 4'd13));
            end
        end
        reset = 1'b1;
        sb.delete();
        #1;
        n_cmp++;
        if ({in_ready, load, add, shift, busy, done} !== 6'b0) begin
            n_bad++;
            $display("FAIL abort_outputs: got %b expected 000000", {in_ready, load, add, shift, busy, done});
        end
        n_cmp++;
        if ({m_out, q_out} !== 8'h00) begin
            n_bad++;
            $display("FAIL abort_operands: got %h expected 00", {m_out, q_out});
        end
        cyc();
        n_cmp++;
        if (obs !== 5'b0) begin
            n_bad++;
            $display("FAIL abort_held: got %b expected 00000", obs);
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL abort_ready: got %b expected 1", in_ready);
        end
        test_multiply(4'd11, 4'd13, "abort_rerun");
    endtask

    initial begin
        test_reset();
        test_multiply(4'd11, 4'd13, "mul_11x13");
        test_multiply(4'd15, 4'd0,  "mul_15x0");
        test_multiply(4'd15, 4'd15, "mul_15x15");
        test_multiply(4'd7,  4'd9,  "mul_7x9");
        test_done_hold();
        test_ignore_inputs();
        test_back_to_back();
        test_abort();
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
